// File: rtl/led_pattern_driver.sv
// ---------------------------------------------------------------------------
// led_pattern_driver
//   Multi-channel LED pattern driver. A shared prescaler produces four rate
//   strobes; each channel picks a rate and a mode (off / on / blink /
//   heartbeat double-flash).
//
// Ports
//   i_clock      system clock, rising edge
//   i_reset_n    asynchronous active-low reset
//   i_enable     global enable; low parks prescaler and LEDs
//   i_mode       per-channel mode, channel c at [2c+1:2c]
//   i_rate_sel   per-channel rate index, channel c at [2c+1:2c]
//   o_led_drive  registered LED outputs
//   o_tick       registered one-cycle rate strobes
// ---------------------------------------------------------------------------

// Per-channel pattern state: phase, heartbeat step and config tracking.
module led_channel (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic       i_enable,
   input  logic [1:0] i_mode,
   input  logic [1:0] i_rate_sel,
   input  logic [3:0] i_tick,
   output logic       o_led
);
   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_HEART = 2'b11
   } mode_e;

   logic       ph_q, ph_d;
   logic [2:0] st_q, st_d;
   logic [1:0] prev_mode_q, prev_mode_d;
   logic [1:0] prev_rate_q, prev_rate_d;
   logic       led_q, led_d;
   logic       cfg_change;

   assign cfg_change = {i_mode, i_rate_sel} != {prev_mode_q, prev_rate_q};

   always_comb begin
      ph_d        = ph_q;
      st_d        = st_q;
      // Config tracking runs even while disabled so re-enable is not a restart.
      prev_mode_d = i_mode;
      prev_rate_d = i_rate_sel;
      led_d       = 1'b0;
      if (!i_enable) begin
         ph_d = 1'b1;
         st_d = 3'd0;
      end else begin
         if (cfg_change) begin
            // Restart takes priority over a coincident tick.
            ph_d = 1'b1;
            st_d = 3'd0;
         end else if (i_tick[i_rate_sel]) begin
            if (mode_e'(i_mode) == MODE_BLINK) ph_d = ~ph_q;
            if (mode_e'(i_mode) == MODE_HEART) st_d = st_q + 3'd1;
         end
         // Output follows the state being written on this same edge.
         case (mode_e'(i_mode))
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = ph_d;
            MODE_HEART: led_d = (st_d == 3'd0) || (st_d == 3'd2);
            default:    led_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         ph_q        <= 1'b0;
         st_q        <= 3'd0;
         prev_mode_q <= 2'b00;
         prev_rate_q <= 2'b00;
         led_q       <= 1'b0;
      end else begin
         ph_q        <= ph_d;
         st_q        <= st_d;
         prev_mode_q <= prev_mode_d;
         prev_rate_q <= prev_rate_d;
         led_q       <= led_d;
      end
   end

   assign o_led = led_q;
endmodule

module led_pattern_driver #(
   parameter int unsigned CLK_HZ   = 25000000,
   parameter int unsigned NUM_CH   = 4,
   parameter int unsigned RATE0_HZ = 100,
   parameter int unsigned RATE1_HZ = 50,
   parameter int unsigned RATE2_HZ = 10,
   parameter int unsigned RATE3_HZ = 1
) (
   input  logic                  i_clock,
   input  logic                  i_reset_n,
   input  logic                  i_enable,
   input  logic [2*NUM_CH-1:0]   i_mode,
   input  logic [2*NUM_CH-1:0]   i_rate_sel,
   output logic [NUM_CH-1:0]     o_led_drive,
   output logic [3:0]            o_tick
);
   localparam int unsigned HALF [4] = '{
      CLK_HZ / (2 * RATE0_HZ),
      CLK_HZ / (2 * RATE1_HZ),
      CLK_HZ / (2 * RATE2_HZ),
      CLK_HZ / (2 * RATE3_HZ)
   };

   // Prescaler: one wrap counter per rate; the tick is registered so it is
   // seen by the channels one cycle after the wrap edge.
   for (genvar k = 0; k < 4; k++) begin : g_rate
      localparam int unsigned H = HALF[k];
      localparam int          W = (H < 2) ? 1 : $clog2(H);

      if (H < 2) begin : g_bad_half
         $error("led_pattern_driver: HALF for rate %0d is %0d, must be >= 2", k, H);
      end

      logic [W-1:0] cnt_q, cnt_d;
      logic         tick_q, tick_d;

      always_comb begin
         cnt_d  = '0;
         tick_d = 1'b0;
         if (i_enable) begin
            if (cnt_q == W'(H - 1)) begin
               cnt_d  = '0;
               tick_d = 1'b1;
            end else begin
               cnt_d = cnt_q + W'(1);
            end
         end
      end

      always_ff @(posedge i_clock or negedge i_reset_n) begin
         if (!i_reset_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
         end
      end

      assign o_tick[k] = tick_q;
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      led_channel u_ch (
         .i_clock    (i_clock),
         .i_reset_n  (i_reset_n),
         .i_enable   (i_enable),
         .i_mode     (i_mode[2*c +: 2]),
         .i_rate_sel (i_rate_sel[2*c +: 2]),
         .i_tick     (o_tick),
         .o_led      (o_led_drive[c])
      );
   end
endmodule

// File: tb/tb_led_pattern_driver.sv
// ---------------------------------------------------------------------------
// tb_led_pattern_driver
//   Scoreboard bench: each clock edge the stimulus side advances a reference
//   model (edge count since enable, restart point per channel, ticks counted
//   arithmetically) and queues the expected {o_tick, o_led_drive}; a monitor
//   on the falling edge pops and compares.
// ---------------------------------------------------------------------------
module tb_led_pattern_driver;
   localparam int NUM_CH = 4;
   localparam int H [4] = '{5, 10, 50, 500};

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                en = 1'b0;
   logic [2*NUM_CH-1:0] mode = '0;
   logic [2*NUM_CH-1:0] rate = '0;
   logic [NUM_CH-1:0]   led;
   logic [3:0]          tick;

   int checks = 0;
   int passed = 0;
   logic [7:0] sbq [$];

   // reference model state
   int         m;              // enabled edges since last disable/reset
   int         base [NUM_CH];  // edge index of last pattern restart
   logic [3:0] prev [NUM_CH];

   always #5 clk = ~clk;

   led_pattern_driver #(
      .CLK_HZ(1000), .NUM_CH(NUM_CH),
      .RATE0_HZ(100), .RATE1_HZ(50), .RATE2_HZ(10), .RATE3_HZ(1)
   ) dut (
      .i_clock     (clk),
      .i_reset_n   (rst_n),
      .i_enable    (en),
      .i_mode      (mode),
      .i_rate_sel  (rate),
      .o_led_drive (led),
      .o_tick      (tick)
   );

   // Monitor
   always @(negedge clk) begin
      if (sbq.size() > 0) begin
         logic [7:0] exp_v;
         exp_v = sbq.pop_front();
         checks++;
         if ({tick, led} === exp_v) passed++;
         else $display("FAIL sb t=%0t m=%0d got tick=%b led=%b exp tick=%b led=%b",
                       $time, m, tick, led, exp_v[7:4], exp_v[3:0]);
      end
   end

   task automatic set_ch(input int c, input logic [1:0] md, input logic [1:0] rt);
      mode[2*c +: 2] = md;
      rate[2*c +: 2] = rt;
   endtask

   // One clock edge: update the model from the inputs sampled there.
   task automatic step();
      logic [7:0] exp_v;
      @(posedge clk);
      exp_v = '0;
      if (!rst_n) begin
         m = 0;
         for (int c = 0; c < NUM_CH; c++) begin base[c] = 0; prev[c] = '0; end
      end else if (!en) begin
         m = 0;
         for (int c = 0; c < NUM_CH; c++) begin
            base[c] = 0;
            prev[c] = {mode[2*c +: 2], rate[2*c +: 2]};
         end
      end else begin
         m++;
         for (int k = 0; k < 4; k++) exp_v[4+k] = (m % H[k] == 0);
         for (int c = 0; c < NUM_CH; c++) begin
            logic [3:0] cfg;
            int hh, cnt, b;
            cfg = {mode[2*c +: 2], rate[2*c +: 2]};
            if (cfg != prev[c]) begin prev[c] = cfg; base[c] = m; end
            hh  = H[cfg[1:0]];
            b   = (base[c] > 1) ? base[c] : 1;
            // ticks consumed since restart: strobes visible on edges base+1..m
            cnt = (m - 1) / hh - (b - 1) / hh;
            case (cfg[3:2])
               2'b00: exp_v[c] = 1'b0;
               2'b01: exp_v[c] = 1'b1;
               2'b10: exp_v[c] = (cnt % 2 == 0);
               default: exp_v[c] = ((cnt % 8) == 0) || ((cnt % 8) == 2);
            endcase
         end
      end
      sbq.push_back(exp_v);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // Asynchronous reset in the middle of a cycle: outputs must clear at once.
   task automatic mid_reset(input string name);
      step();
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({tick, led} === 8'h00) passed++;
      else $display("FAIL %s got tick=%b led=%b exp 0000/0000", name, tick, led);
      sbq.delete();
      sbq.push_back(8'h00);
      run(2);
      rst_n = 1'b1;
   endtask

   initial begin
      m = 0;
      for (int c = 0; c < NUM_CH; c++) begin base[c] = 0; prev[c] = '0; end

      // Reset held 3 cycles, released with enable low
      run(3);
      rst_n = 1'b1;
      run(6);

      // Rate check: ch c blinks at rate c
      for (int c = 0; c < NUM_CH; c++) set_ch(c, 2'b10, 2'(c));
      en = 1'b1;
      run(1100);
      mid_reset("reset_mid_blink");
      run(120);

      // Heartbeat on ch0 rate 0
      for (int c = 0; c < NUM_CH; c++) set_ch(c, 2'b00, 2'b00);
      set_ch(0, 2'b11, 2'b00);
      run(130);

      // Restart: ch1 rate 1, switch to rate 0 on a tick edge
      set_ch(0, 2'b00, 2'b00);
      set_ch(1, 2'b10, 2'b01);
      run(37);
      for (int i = 0; i < 20 && (m % 10) != 0; i++) step();
      set_ch(1, 2'b10, 2'b00);
      run(40);

      // Enable toggle mid-pattern, then the rate-check sequence again
      for (int c = 0; c < NUM_CH; c++) set_ch(c, 2'b10, 2'(c));
      run(237);
      en = 1'b0;
      run(3);
      en = 1'b1;
      run(1050);

      // Static modes
      set_ch(0, 2'b01, 2'b00);
      set_ch(1, 2'b00, 2'b10);
      set_ch(2, 2'b01, 2'b11);
      run(30);
      set_ch(0, 2'b00, 2'b00);
      run(10);

      // Config change coincident with enable falling
      set_ch(3, 2'b11, 2'b01);
      en = 1'b0;
      run(2);
      en = 1'b1;
      run(60);

      // Randomized
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(19, 0) == 0)
            set_ch(int'($urandom_range(NUM_CH-1, 0)), 2'($urandom_range(3, 0)),
                   2'($urandom_range(3, 0)));
         if ($urandom_range(149, 0) == 0) en = ~en;
         if ($urandom_range(799, 0) == 0) mid_reset("reset_rand");
         else step();
      end
      en = 1'b1;
      run(20);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
